// File: rtl/a_lane_fifo_if.sv
// Handshake bundle for a_lane_fifo: producer side (in_*), consumer side (out_*) and fill level.
// out_sum exists only when A_LANE_FIFO_SUM_EN is defined.
interface a_lane_fifo_if #(
  parameter int WIDTH = 8,
  parameter int LANES = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int DW = LANES * WIDTH;

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] level;
`ifdef A_LANE_FIFO_SUM_EN
  logic [WIDTH+$clog2(LANES)-1:0] out_sum;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, level, out_sum
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, level, out_sum
  );
`else
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, level
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, level
  );
`endif
endinterface

// File: rtl/a_lane_fifo.sv
// a_lane_fifo: DEPTH-entry first-word-fall-through FIFO of LANES x WIDTH lane vectors with valid/ready on both sides.
// Define A_LANE_FIFO_SUM_EN to add out_sum, the unsigned sum of the head entry's lanes.
module a_lane_fifo #(
  parameter int WIDTH = 8,
  parameter int LANES = 8,
  parameter int DEPTH = 4
) (
  input logic          clock,
  input logic          reset,
  a_lane_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int DW = LANES * WIDTH;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] level_q, level_d;
  logic          inReady;
  logic          outValid;
  logic          push;
  logic          pop;
  logic [DW-1:0] head;

  // Handshakes come only from registered state; gating with reset keeps both sides idle while it is held.
  assign inReady  = reset && (level_q != CW'(DEPTH));
  assign outValid = reset && (level_q != '0);
  assign push     = bus.in_valid && inReady;
  assign pop      = outValid && bus.out_ready;
  assign head     = outValid ? mem[rdPtr_q] : '0;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    level_d = level_q;
    if (push) wrPtr_d = wrPtr_q + AW'(1);
    if (pop)  rdPtr_d = rdPtr_q + AW'(1);
    if (push && !pop)      level_d = level_q + CW'(1);
    else if (pop && !push) level_d = level_q - CW'(1);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      level_q <= level_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (push) mem[wrPtr_q] <= bus.in_data;
  end

  assign bus.in_ready  = inReady;
  assign bus.out_valid = outValid;
  assign bus.out_data  = head;
  assign bus.level     = level_q;

`ifdef A_LANE_FIFO_SUM_EN
  localparam int SW = WIDTH + $clog2(LANES);
  logic [SW-1:0] laneSum;

  always_comb begin
    laneSum = '0;
    for (int k = 0; k < LANES; k++) begin
      laneSum = laneSum + SW'(head[k*WIDTH +: WIDTH]);
    end
  end

  assign bus.out_sum = laneSum;
`endif
endmodule

// File: tb/tb_a_lane_fifo.sv
// Testbench for a_lane_fifo: directed beats feed an expected-value queue, a negedge monitor checks the DUT against it.
// Builds with or without A_LANE_FIFO_SUM_EN.
module tb_a_lane_fifo;
  localparam int WIDTH = 8;
  localparam int LANES = 8;
  localparam int DEPTH = 4;
  localparam int DW    = LANES * WIDTH;

  logic clock;
  logic reset;
  int   vectors;
  int   miscompares;
  int   consumerMode;
  logic [DW-1:0] expQ [$];

  a_lane_fifo_if #(.WIDTH(WIDTH), .LANES(LANES), .DEPTH(DEPTH)) bus ();

  a_lane_fifo #(.WIDTH(WIDTH), .LANES(LANES), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] laneSumOf(input logic [DW-1:0] d);
    logic [DW-1:0] s = '0;
    for (int k = 0; k < LANES; k++) s = s + DW'(d[k*WIDTH +: WIDTH]);
    return s;
  endfunction

  // Offer one beat starting just after a rising edge; the expectation is queued once the beat is taken.
  task automatic applyStimulus(input logic [DW-1:0] d);
    bit taken = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int n = 0; n < 100 && !taken; n++) begin
      @(negedge clock);
      taken = bus.in_ready;
      @(posedge clock);
      #1;
    end
    if (taken) expQ.push_back(d);
    else checkOutput("push_timeout", 0, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic waitDrain(input int budget);
    for (int n = 0; n < budget && expQ.size() != 0; n++) begin
      @(posedge clock);
      #1;
    end
    checkOutput("drain", DW'(expQ.size()), 0);
  endtask

  // Consumer: out_ready updated just after each rising edge, after the driver has acted.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clock);
      #2;
      case (consumerMode)
        0:       bus.out_ready = 1'b0;
        1:       bus.out_ready = 1'b1;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: mid-cycle compare of head/level against the model; a pop is retired from the queue here.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        checkOutput("rst_in_ready", DW'(bus.in_ready), 0);
        checkOutput("rst_out_valid", DW'(bus.out_valid), 0);
        checkOutput("rst_out_data", bus.out_data, 0);
`ifdef A_LANE_FIFO_SUM_EN
        checkOutput("rst_out_sum", DW'(bus.out_sum), 0);
`endif
      end else begin
        checkOutput("level", DW'(bus.level), DW'(expQ.size()));
        checkOutput("out_valid", DW'(bus.out_valid), DW'(expQ.size() != 0));
        if (expQ.size() != 0) begin
          checkOutput("out_data", bus.out_data, expQ[0]);
`ifdef A_LANE_FIFO_SUM_EN
          checkOutput("out_sum", DW'(bus.out_sum), laneSumOf(expQ[0]));
`endif
          if (bus.out_ready) void'(expQ.pop_front());
        end
      end
    end
  end

  initial begin
    vectors      = 0;
    miscompares  = 0;
    consumerMode = 0;
    reset        = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 64'hDEAD_BEEF_0123_4567;

    // Reset held with a beat offered
    repeat (2) @(posedge clock);
    #1;
    @(negedge clock);
    checkOutput("rst_level", DW'(bus.level), 0);
    @(posedge clock);
    #1;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clock);
    checkOutput("post_rst_in_ready", DW'(bus.in_ready), 1);
    @(posedge clock);
    #1;

    // Single beat, no consumer
    applyStimulus(64'h0807_0605_0403_0201);
    @(negedge clock);
    checkOutput("single_level", DW'(bus.level), 1);
    checkOutput("single_data", bus.out_data, 64'h0807_0605_0403_0201);
`ifdef A_LANE_FIFO_SUM_EN
    checkOutput("single_sum", DW'(bus.out_sum), 36);
`endif
    @(posedge clock);
    #1;
    consumerMode = 1;
    waitDrain(20);

    // Fill to full, fifth beat stalls until a pop
    consumerMode = 0;
    @(posedge clock);
    #1;
    applyStimulus(64'h10);
    applyStimulus(64'h20);
    applyStimulus(64'h30);
    applyStimulus(64'h40);
    @(negedge clock);
    checkOutput("full_level", DW'(bus.level), 4);
    checkOutput("full_in_ready", DW'(bus.in_ready), 0);
    @(posedge clock);
    #1;
    fork
      applyStimulus(64'h50);
      begin
        repeat (3) begin
          @(negedge clock);
          checkOutput("full_hold_level", DW'(bus.level), 4);
        end
        @(posedge clock);
        #1;
        consumerMode = 1;
      end
    join
    waitDrain(30);

    // Level 2 streaming with simultaneous push and pop
    consumerMode = 0;
    applyStimulus({8{8'd0}});
    applyStimulus({8{8'd1}});
    consumerMode = 1;
    for (int i = 2; i < 22; i++) begin
      applyStimulus({8{8'(i)}});
    end
    consumerMode = 0;
    @(negedge clock);
    checkOutput("stream_level", DW'(bus.level), 2);
    @(posedge clock);
    #1;
    consumerMode = 1;
    waitDrain(20);

    // Random backpressure, first head 0xA5 on every lane
    consumerMode = 2;
    for (int i = 0; i < 200; i++) begin
      applyStimulus({8{8'hA5}} ^ {8{8'(i)}});
    end
    waitDrain(2000);

    // Reset with three beats stored
    consumerMode = 0;
    @(posedge clock);
    #1;
    applyStimulus(64'h11);
    applyStimulus(64'h22);
    applyStimulus(64'h33);
    @(negedge clock);
    checkOutput("pre_rst_level", DW'(bus.level), 3);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    expQ.delete();
    reset = 1'b1;
    @(negedge clock);
    checkOutput("mid_rst_in_ready", DW'(bus.in_ready), 1);
    checkOutput("mid_rst_level", DW'(bus.level), 0);
    @(posedge clock);
    #1;
    applyStimulus(64'h77);
    @(negedge clock);
    checkOutput("after_rst_head", bus.out_data, 64'h77);
    @(posedge clock);
    #1;
    consumerMode = 1;
    waitDrain(20);

    repeat (2) @(posedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
